// File: rtl/fli_wb_arbiter_pkg.sv
// Shared types and configuration defaults for the FLI writeback arbiter.
// FLEN is the FP register width; the FIFO depth and starvation limit are module defaults.
package fli_wb_arbiter_pkg;

    localparam int unsigned FLEN        = 64;
    localparam int unsigned FliDepth    = 2;
    localparam int unsigned StarveLimit = 4;

    typedef struct packed {
        logic [4:0] Rs1;
        logic [1:0] Fmt;
        logic [4:0] Rd;
    } fli_req_t;

    typedef struct packed {
        logic [FLEN-1:0] Imm;
        logic [4:0]      Rd;
    } fli_res_t;

endpackage

// File: rtl/fli_wb_arbiter_if.sv
// Bus bundle between decode, the fli generator, the div/sqrt unit and FP writeback.
// The slave modport is the arbiter's view; master is the surrounding FPU.
interface fli_wb_arbiter_if;
    import fli_wb_arbiter_pkg::*;

    logic            FliValidD;
    logic            FliReadyD;
    logic [4:0]      FliRs1D;
    logic [1:0]      FliFmtD;
    logic [4:0]      FliRdD;
    logic            FlushE;
    logic [4:0]      FliRs1;
    logic [1:0]      FliFmt;
    logic [FLEN-1:0] FliImm;
    logic            DivValidM;
    logic [FLEN-1:0] DivResM;
    logic [4:0]      DivRdM;
    logic            DivReadyM;
    logic            FRegWriteW;
    logic [FLEN-1:0] FResultW;
    logic [4:0]      FRdW;
    logic            FliBusy;

    modport slave (
        input  FliValidD, FliRs1D, FliFmtD, FliRdD, FlushE, FliImm,
        input  DivValidM, DivResM, DivRdM,
        output FliReadyD, FliRs1, FliFmt, DivReadyM, FRegWriteW, FResultW, FRdW, FliBusy
    );

    modport master (
        output FliValidD, FliRs1D, FliFmtD, FliRdD, FlushE, FliImm,
        output DivValidM, DivResM, DivRdM,
        input  FliReadyD, FliRs1, FliFmt, DivReadyM, FRegWriteW, FResultW, FRdW, FliBusy
    );

endinterface

// File: rtl/fli_wb_arbiter_fifo.sv
// Generic synchronous FIFO holding generated FLI results until the write port is granted.
// DEPTH must be a power of two so the pointers wrap naturally.
module fli_wb_arbiter_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_wdata,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == CntFull);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fli_wb_arbiter.sv
// Sequences FLI requests through the fli generator, buffers the immediates and arbitrates
// the FP register-file write port against div/sqrt completions with FLI starvation protection.
module fli_wb_arbiter
    import fli_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = FliDepth,
    parameter int unsigned STARVE_LIMIT = StarveLimit
) (
    input logic             clk,
    input logic             reset,
    fli_wb_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [StW-1:0] StMax = StW'(STARVE_LIMIT);

    fli_req_t        r_gen;
    logic            r_gen_valid;
    logic [StW-1:0]  r_starve;

    fli_res_t        w_push_data;
    fli_res_t        w_head;
    logic            w_full;
    logic            w_empty;
    logic [CntW-1:0] w_count;
    logic            w_fli_pop;
    logic            w_div_ready;
    logic            w_div_grant;
    logic            w_gen_adv;
    logic            w_push;
    logic            w_ready;
    logic            w_accept;

    fli_wb_arbiter_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fli_res_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_fli_pop),
        .i_wdata (w_push_data),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Div wins while the FLI head has waited fewer than STARVE_LIMIT cycles.
    assign w_fli_pop   = ~reset & ~w_empty & (~bus.DivValidM | (r_starve == StMax));
    assign w_div_ready = ~reset & (w_empty | (bus.DivValidM & (r_starve < StMax)));
    assign w_div_grant = bus.DivValidM & w_div_ready;

    assign w_gen_adv   = r_gen_valid & (~w_full | w_fli_pop);
    assign w_push      = ~reset & ~bus.FlushE & w_gen_adv;
    assign w_ready     = ~reset & ~bus.FlushE & (~r_gen_valid | w_gen_adv);
    assign w_accept    = bus.FliValidD & w_ready;
    assign w_push_data = '{Imm: bus.FliImm, Rd: r_gen.Rd};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gen_valid <= 1'b0;
            r_gen       <= '0;
            r_starve    <= '0;
        end else begin
            if (w_accept) begin
                r_gen_valid <= 1'b1;
                r_gen       <= '{Rs1: bus.FliRs1D, Fmt: bus.FliFmtD, Rd: bus.FliRdD};
            end else if (bus.FlushE || w_gen_adv) begin
                r_gen_valid <= 1'b0;
            end
            if (w_fli_pop || w_empty) begin
                r_starve <= '0;
            end else if (bus.DivValidM && (r_starve < StMax)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    always_comb begin
        bus.FliReadyD  = w_ready;
        bus.DivReadyM  = w_div_ready;
        bus.FRegWriteW = w_fli_pop | w_div_grant;
        bus.FResultW   = '0;
        bus.FRdW       = '0;
        if (w_fli_pop) begin
            bus.FResultW = w_head.Imm;
            bus.FRdW     = w_head.Rd;
        end else if (w_div_grant) begin
            bus.FResultW = bus.DivResM;
            bus.FRdW     = bus.DivRdM;
        end
        bus.FliRs1  = (r_gen_valid && !reset) ? r_gen.Rs1 : '0;
        bus.FliFmt  = (r_gen_valid && !reset) ? r_gen.Fmt : '0;
        bus.FliBusy = ~reset & (r_gen_valid | (w_count != '0));
    end

endmodule

// File: tb/tb_fli_wb_arbiter.sv
// Directed self-checking bench for fli_wb_arbiter with a combinational fli generator model.
module tb_fli_wb_arbiter;
    import fli_wb_arbiter_pkg::*;

    localparam logic [63:0] DivRes = 64'hD1D1_D1D1_0000_7777;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [4:0] erd;

    fli_wb_arbiter_if bus ();

    fli_wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [63:0] fli_model(input logic [4:0] rs1, input logic [1:0] fmt);
        if (rs1 == 5'd16 && fmt == 2'b00) return 64'hFFFF_FFFF_3F80_0000;
        return {32'hFFFF_FFFF, 8'hC0, 17'h0, fmt, rs1};
    endfunction

    assign bus.FliImm = fli_model(bus.FliRs1, bus.FliFmt);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [4:0] rs1, input logic [1:0] fmt,
                       input logic [4:0] rd);
        bus.FliValidD = v;
        bus.FliRs1D   = rs1;
        bus.FliFmtD   = fmt;
        bus.FliRdD    = rd;
    endtask

    task automatic div(input logic v, input logic [4:0] rd, input logic [63:0] res);
        bus.DivValidM = v;
        bus.DivRdM    = rd;
        bus.DivResM   = res;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},   64'(bus.FliReadyD), 64'd0);
        chk({tag, "_drdy"},  64'(bus.DivReadyM), 64'd0);
        chk({tag, "_we"},    64'(bus.FRegWriteW), 64'd0);
        chk({tag, "_res"},   bus.FResultW, 64'd0);
        chk({tag, "_rd"},    64'(bus.FRdW), 64'd0);
        chk({tag, "_rs1"},   64'(bus.FliRs1), 64'd0);
        chk({tag, "_fmt"},   64'(bus.FliFmt), 64'd0);
        chk({tag, "_busy"},  64'(bus.FliBusy), 64'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.FlushE = 1'b0;
        req(1'b0, 5'd0, 2'd0, 5'd0);
        div(1'b0, 5'd0, 64'd0);

        // Reset: outputs held at zero even with live inputs.
        tick();
        req(1'b1, 5'd16, 2'd0, 5'd3);
        div(1'b1, 5'd9, DivRes);
        #1;
        chk_all_zero("rst");
        tick();
        tick();
        reset = 1'b0;
        req(1'b0, 5'd0, 2'd0, 5'd0);
        div(1'b0, 5'd0, 64'd0);

        // Idle div completion goes straight through.
        div(1'b1, 5'd9, DivRes);
        #1;
        chk("idle_div_we",  64'(bus.FRegWriteW), 64'd1);
        chk("idle_div_rdy", 64'(bus.DivReadyM), 64'd1);
        chk("idle_div_rd",  64'(bus.FRdW), 64'd9);
        chk("idle_div_res", bus.FResultW, DivRes);
        tick();
        div(1'b0, 5'd0, 64'd0);

        // Single request: 2-cycle latency.
        req(1'b1, 5'd16, 2'b00, 5'd3);
        #1;
        chk("t1_rdy", 64'(bus.FliReadyD), 64'd1);
        chk("t1_we0", 64'(bus.FRegWriteW), 64'd0);
        tick();
        req(1'b0, 5'd0, 2'd0, 5'd0);
        #1;
        chk("t1_gen_rs1", 64'(bus.FliRs1), 64'd16);
        chk("t1_we1",     64'(bus.FRegWriteW), 64'd0);
        chk("t1_busy1",   64'(bus.FliBusy), 64'd1);
        tick();
        #1;
        chk("t1_we2",  64'(bus.FRegWriteW), 64'd1);
        chk("t1_rd2",  64'(bus.FRdW), 64'd3);
        chk("t1_res2", bus.FResultW, 64'hFFFF_FFFF_3F80_0000);
        tick();
        #1;
        chk("t1_we3",   64'(bus.FRegWriteW), 64'd0);
        chk("t1_busy3", 64'(bus.FliBusy), 64'd0);
        tick();

        // Four back-to-back requests, writes on consecutive cycles.
        for (int i = 0; i < 7; i++) begin
            if (i < 4) req(1'b1, 5'(i + 1), 2'b01, 5'(i + 1));
            else       req(1'b0, 5'd0, 2'd0, 5'd0);
            #1;
            if (i < 4) chk("t2_rdy", 64'(bus.FliReadyD), 64'd1);
            chk("t2_we", 64'(bus.FRegWriteW), (i >= 2 && i < 6) ? 64'd1 : 64'd0);
            if (i >= 2 && i < 6) begin
                chk("t2_rd",  64'(bus.FRdW), 64'(i - 1));
                chk("t2_res", bus.FResultW, fli_model(5'(i - 1), 2'b01));
            end
            tick();
        end
        chk("t2_busy_end", 64'(bus.FliBusy), 64'd0);

        // Div held valid: 4 div writes, then one forced FLI write, repeating.
        div(1'b1, 5'd7, DivRes);
        for (int c = 0; c <= 16; c++) begin
            if (c < 3) req(1'b1, 5'(10 + c), 2'b10, 5'(10 + c));
            else       req(1'b0, 5'd0, 2'd0, 5'd0);
            #1;
            erd = (c == 6) ? 5'd10 : (c == 11) ? 5'd11 : (c == 16) ? 5'd12 : 5'd7;
            chk("t3_we",   64'(bus.FRegWriteW), 64'd1);
            chk("t3_rd",   64'(bus.FRdW), 64'(erd));
            chk("t3_drdy", 64'(bus.DivReadyM), (erd != 5'd7) ? 64'd0 : 64'd1);
            chk("t3_rdy",  64'(bus.FliReadyD), (c >= 3 && c <= 5) ? 64'd0 : 64'd1);
            chk("t3_res",  bus.FResultW, (erd != 5'd7) ? fli_model(erd, 2'b10) : DivRes);
            tick();
        end
        div(1'b0, 5'd0, 64'd0);
        #1;
        chk("t3_we_end",   64'(bus.FRegWriteW), 64'd0);
        chk("t3_busy_end", 64'(bus.FliBusy), 64'd0);
        tick();

        // Flush kills the Gen-stage request.
        req(1'b1, 5'd5, 2'b00, 5'd5);
        #1;
        chk("t4_rdy0", 64'(bus.FliReadyD), 64'd1);
        tick();
        bus.FlushE = 1'b1;
        req(1'b1, 5'd6, 2'b00, 5'd6);
        #1;
        chk("t4_rdy_flush", 64'(bus.FliReadyD), 64'd0);
        chk("t4_we1",       64'(bus.FRegWriteW), 64'd0);
        tick();
        bus.FlushE = 1'b0;
        req(1'b0, 5'd0, 2'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_we",   64'(bus.FRegWriteW), 64'd0);
            chk("t4_busy", 64'(bus.FliBusy), 64'd0);
            tick();
        end

        // Full FIFO with Gen valid, then push and pop together.
        for (int c = 0; c <= 8; c++) begin
            if (c < 3 || c == 4) req(1'b1, 5'(20 + c - (c == 4 ? 1 : 0)), 2'b11,
                                     5'(20 + c - (c == 4 ? 1 : 0)));
            else                 req(1'b0, 5'd0, 2'd0, 5'd0);
            div(c < 4, 5'd7, DivRes);
            #1;
            if (c <= 4) chk("t5_rdy", 64'(bus.FliReadyD), (c == 3) ? 64'd0 : 64'd1);
            chk("t5_we", 64'(bus.FRegWriteW), (c < 8) ? 64'd1 : 64'd0);
            if (c < 4) begin
                chk("t5_rd_div", 64'(bus.FRdW), 64'd7);
            end else if (c < 8) begin
                chk("t5_rd",  64'(bus.FRdW), 64'(16 + c));
                chk("t5_res", bus.FResultW, fli_model(5'(16 + c), 2'b11));
            end
            chk("t5_busy", 64'(bus.FliBusy), (c >= 1 && c <= 7) ? 64'd1 : 64'd0);
            tick();
        end

        // Reset with FIFO full and Gen valid discards everything.
        for (int c = 0; c < 4; c++) begin
            if (c < 3) req(1'b1, 5'(30 + c), 2'b00, 5'(30 + c));
            else       req(1'b0, 5'd0, 2'd0, 5'd0);
            div(1'b1, 5'd7, DivRes);
            #1;
            if (c == 3) begin
                chk("t6_full_rdy",  64'(bus.FliReadyD), 64'd0);
                chk("t6_full_busy", 64'(bus.FliBusy), 64'd1);
            end
            tick();
        end
        reset = 1'b1;
        req(1'b1, 5'd1, 2'b01, 5'd1);
        #1;
        chk_all_zero("t6_rst_a");
        tick();
        chk_all_zero("t6_rst_b");
        tick();
        reset = 1'b0;
        req(1'b0, 5'd0, 2'd0, 5'd0);
        div(1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_we",   64'(bus.FRegWriteW), 64'd0);
            chk("t6_busy", 64'(bus.FliBusy), 64'd0);
            chk("t6_rdy",  64'(bus.FliReadyD), 64'd1);
            tick();
        end
        div(1'b1, 5'd9, DivRes);
        #1;
        chk("t6_div_rd",   64'(bus.FRdW), 64'd9);
        chk("t6_div_drdy", 64'(bus.DivReadyM), 64'd1);
        tick();
        div(1'b0, 5'd0, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fli_wb_arbiter.md
Name: fli_wb_arbiter

Overview:
- Sequences FLI (load-FP-immediate) requests from decode through the shared combinational `fli` constant generator.
- Buffers generated immediates in a small result FIFO.
- Arbitrates the single FP register-file write port between FLI results and long-latency FPU (div/sqrt) completions.
- Sits in the FPU between the decode/issue handshake and the FP writeback stage; includes starvation protection for FLI.

Parameters:
- FLEN, 64, FP register width (from config_pkg).
- DEPTH, 2, result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive cycles a blocked FLI head waits before it preempts the div/sqrt unit.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- FliValidD  in  1  FLI request valid
- FliReadyD  out  1  request accepted when FliValidD & FliReadyD
- FliRs1D  in  5  immediate index
- FliFmtD  in  2  format (00 S, 01 D, 10 H, 11 Q)
- FliRdD  in  5  destination FP register
- FlushE  in  1  kills the request in the Gen stage
- FliRs1  out  5  index driven to the fli generator
- FliFmt  out  2  format driven to the fli generator
- FliImm  in  FLEN  NaN-boxed immediate returned by the fli generator (combinational)
- DivValidM  in  1  div/sqrt result valid
- DivResM  in  FLEN  div/sqrt result
- DivRdM  in  5  div/sqrt destination
- DivReadyM  out  1  div/sqrt result consumed when DivValidM & DivReadyM
- FRegWriteW  out  1  FP register-file write enable
- FResultW  out  FLEN  write data
- FRdW  out  5  write address
- FliBusy  out  1  Gen stage valid or FIFO non-empty

Behaviour:
- Reset: while reset=1, all outputs = 0. At the first clock edge: GenValid=0, FIFO empty (pointers 0, count 0), StarveCnt=0. Reset mid-operation discards all pending FLI work without writing it.
- Gen stage:
  - An accepted request is registered into Gen (Rs1, Fmt, Rd, GenValid=1).
  - FliRs1/FliFmt = Gen register contents; 0 when GenValid=0.
- Advance:
  - GenAdv = GenValid & (count<DEPTH | FliPop).
  - On GenAdv, push {FliImm, GenRd} into the FIFO.
  - Push and pop in the same cycle when full is legal; count is unchanged.
- Ready: FliReadyD = ~FlushE & (~GenValid | GenAdv). Supports back-to-back acceptance at 1/cycle while the FIFO drains.
- FlushE: clears GenValid at the edge; no push from a flushed entry. FIFO entries are never flushed.
- Latency: accept at edge t → Gen valid in cycle t+1 → pushed at edge t+1 → earliest FRegWriteW in cycle t+2 (2 cycles).
- Arbitration each cycle (H = FIFO non-empty):
  - H=0: DivReadyM=1; a div result is written if valid.
  - H=1, DivValidM=0: FliPop=1; write the FIFO head.
  - H=1, DivValidM=1, StarveCnt<STARVE_LIMIT: div wins, DivReadyM=1, FliPop=0, StarveCnt++.
  - H=1, DivValidM=1, StarveCnt==STARVE_LIMIT: FLI wins, DivReadyM=0, FliPop=1.
- StarveCnt: clears to 0 on any FliPop or when H=0; never exceeds STARVE_LIMIT.
- Write port:
  - FRegWriteW = FliPop | (DivValidM & DivReadyM).
  - FResultW/FRdW select the granted source; 0 when no write.
- FIFO pointers: wrap modulo DEPTH; full at count==DEPTH, empty at count==0.
- FliImm sampling: FliImm is sampled only on GenAdv. The bench model of fli must be combinational from FliRs1/FliFmt.

Decomposition:
- fpu_pkg holds typedef fli_res_t {logic [FLEN-1:0] Imm; logic [4:0] Rd;} and typedef fli_req_t {Rs1, Fmt, Rd}.
- STARVE_LIMIT default lives in config_pkg.
- Natural sub-module: fli_res_fifo (generic synchronous FIFO of fli_res_t, DEPTH entries, push/pop/full/empty/count).
- The fli generator is instantiated beside this block at the FPU level, not inside it.

Test Plan:
- Single request: Rs1=16, Fmt=00, Rd=3, fli returns 64'hFFFFFFFF3F800000 → FRegWriteW=1 exactly in cycle t+2, FRdW=3, FResultW=FFFFFFFF3F800000; FliBusy low afterwards.
- Four back-to-back requests (Rd=1..4), DivValidM=0 → FliReadyD stays 1; writes to Rd 1,2,3,4 in four consecutive cycles.
- DivValidM held 1 (Rd=7) plus three FLI requests:
  - FIFO fills to 2 and FliReadyD drops.
  - Div writes Rd 7 for 4 cycles.
  - 5th cycle: DivReadyM=0 and an FLI write occurs.
  - StarveCnt returns to 0 and the pattern repeats.
- Accept Rd=5, assert FlushE in cycle t+1 → no write to Rd 5; FliReadyD=0 during FlushE.
- FIFO full with Gen valid and pop in the same cycle → push+pop occur, count stays 2, order preserved, no lost or duplicated Rd.
- reset asserted with FIFO full and Gen valid → all outputs 0 during reset; after release, FliBusy=0 and no stale writes.
